// File: rtl/i2c_read_master_if.sv
// Command/response bundle for the single-byte I2C read master.
//   cmd_valid/cmd_ready/cmd_addr : read request handshake (7-bit device address)
//   rsp_valid/rsp_data/rsp_nack  : one-cycle completion strobe with held result
//   busy                         : transaction in flight, accept through response
// The requester uses the master modport; the I2C engine uses the slave modport.
interface i2c_read_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_nack;
   logic       busy;

   modport master (
      output cmd_valid, cmd_addr,
      input  cmd_ready, rsp_valid, rsp_data, rsp_nack, busy
   );

   modport slave (
      input  cmd_valid, cmd_addr,
      output cmd_ready, rsp_valid, rsp_data, rsp_nack, busy
   );
endinterface

// File: rtl/i2c_read_master.sv
// Single-byte I2C read master: START, address+R, ACK check, 8 data bits,
// master NACK, STOP. Returns the byte or an address-NACK flag on a strobe.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, aborts any transfer at once
//   cmd    : command/response bundle (slave side)
//   scl    : I2C clock, push-pull
//   sda    : I2C data, open-drain (0 or Z), external pull-up
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | bus free, cmd_ready high, waiting for a command
// START    | 2 quarters, SDA low while SCL high
// ADDR     | 8 slots, address + read bit, MSB first
// ADDR_ACK | 1 slot, SDA released, slave ACK sampled
// READ     | 8 slots, SDA released, data shifted in MSB first
// MNACK    | 1 slot, SDA released so the slave sees a NACK
// STOP     | 4 quarters, SDA rises while SCL high, then bus-free hold
// DONE     | 1 clk, response strobe
module i2c_read_master #(
   parameter int CLK_DIV = 250
) (
   input  logic             clk,
   input  logic             rst_n,
   i2c_read_master_if.slave cmd,
   output logic             scl,
   inout  wire              sda
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      READ,
      MNACK,
      STOP,
      DONE
   } state_t;

   localparam int            QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

   state_t        state;
   logic [QW-1:0] q_cnt;
   logic [1:0]    qtr;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          nack;
   logic          sda_smp;
   logic          sda_low;
   logic          tick_q;
   logic          slot_scl;

   assign tick_q = (q_cnt == Q_LAST);

   // SCL level for the quarter that follows the current one inside a bit slot:
   // Q0/Q1 low, Q2/Q3 high.
   assign slot_scl = (qtr == 2'd1) || (qtr == 2'd2);

   assign sda = sda_low ? 1'b0 : 1'bz;

   // All outputs are registered: on each quarter tick the values for the
   // next quarter are loaded, so they change exactly at quarter boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         q_cnt         <= '0;
         qtr           <= 2'd0;
         bit_cnt       <= 3'd0;
         shift         <= 8'h00;
         nack          <= 1'b0;
         sda_smp       <= 1'b0;
         sda_low       <= 1'b0;
         scl           <= 1'b1;
         cmd.cmd_ready <= 1'b1;
         cmd.busy      <= 1'b0;
         cmd.rsp_valid <= 1'b0;
         cmd.rsp_data  <= 8'h00;
         cmd.rsp_nack  <= 1'b0;
      end else begin
         cmd.rsp_valid <= 1'b0;
         if (state == IDLE) begin
            if (cmd.cmd_valid) begin
               state         <= START;
               q_cnt         <= '0;
               qtr           <= 2'd0;
               shift         <= {cmd.cmd_addr, 1'b1};
               nack          <= 1'b0;
               cmd.cmd_ready <= 1'b0;
               cmd.busy      <= 1'b1;
               scl           <= 1'b1;
               sda_low       <= 1'b1;
            end
         end else if (state == DONE) begin
            state         <= IDLE;
            cmd.cmd_ready <= 1'b1;
            cmd.busy      <= 1'b0;
         end else begin
            q_cnt <= tick_q ? '0 : q_cnt + QW'(1);
            if (tick_q) begin
               qtr <= qtr + 2'd1;
               case (state)
                  START: begin
                     if (qtr == 2'd1) begin
                        state   <= ADDR;
                        qtr     <= 2'd0;
                        bit_cnt <= 3'd7;
                        scl     <= 1'b0;
                        sda_low <= ~shift[7];
                     end
                  end
                  ADDR: begin
                     scl <= slot_scl;
                     if (qtr == 2'd3) begin
                        if (bit_cnt == 3'd0) begin
                           state   <= ADDR_ACK;
                           sda_low <= 1'b0;
                        end else begin
                           bit_cnt <= bit_cnt - 3'd1;
                           sda_low <= ~shift[6];
                        end
                        shift <= {shift[6:0], 1'b0};
                     end
                  end
                  ADDR_ACK: begin
                     scl <= slot_scl;
                     if (qtr == 2'd2) begin
                        sda_smp <= sda;
                     end
                     if (qtr == 2'd3) begin
                        if (sda_smp) begin
                           // Nobody answered: skip the data phase, go to STOP.
                           nack    <= 1'b1;
                           state   <= STOP;
                           sda_low <= 1'b1;
                        end else begin
                           state   <= READ;
                           bit_cnt <= 3'd7;
                        end
                     end
                  end
                  READ: begin
                     scl <= slot_scl;
                     if (qtr == 2'd2) begin
                        shift <= {shift[6:0], sda};
                     end
                     if (qtr == 2'd3) begin
                        if (bit_cnt == 3'd0) begin
                           state <= MNACK;
                        end else begin
                           bit_cnt <= bit_cnt - 3'd1;
                        end
                     end
                  end
                  MNACK: begin
                     scl <= slot_scl;
                     if (qtr == 2'd3) begin
                        state   <= STOP;
                        sda_low <= 1'b1;
                     end
                  end
                  STOP: begin
                     // Q0 low/low, Q1 SCL up with SDA low, Q2/Q3 SDA released.
                     scl     <= 1'b1;
                     sda_low <= (qtr == 2'd0);
                     if (qtr == 2'd3) begin
                        state         <= DONE;
                        cmd.rsp_valid <= 1'b1;
                        cmd.rsp_data  <= nack ? 8'h00 : shift;
                        cmd.rsp_nack  <= nack;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_read_master.sv
// Directed bench for i2c_read_master: two instances (CLK_DIV 8 and 250) share
// one open-drain bus with a behavioural switch slave at 0x57.
module tb_i2c_read_master;

   localparam int CD_A = 8;
   localparam int CD_B = 250;

   logic clk;
   logic rst_n;

   i2c_read_master_if ifa ();
   i2c_read_master_if ifb ();

   logic scl_a;
   logic scl_b;
   wire  scl_bus;
   wire  sda;
   logic sl_drv = 1'b0;
   logic tb_drv = 1'b0;

   assign scl_bus = scl_a & scl_b;
   pullup (sda);
   assign sda = (sl_drv | tb_drv) ? 1'b0 : 1'bz;

   i2c_read_master #(.CLK_DIV(CD_A)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .cmd   (ifa),
      .scl   (scl_a),
      .sda   (sda)
   );

   i2c_read_master #(.CLK_DIV(CD_B)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .cmd   (ifb),
      .scl   (scl_b),
      .sda   (sda)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- switch slave + bus monitor ----------------
   localparam int M_IDLE = 0, M_ADDR = 1, M_ACK = 2, M_DATA = 3, M_MACK = 4;

   logic [7:0] sw = 8'hA5;
   int         clr_seq = 0;
   int         clr_seen = 0;
   int         mode = M_IDLE;
   int         acnt = 0;
   int         dcnt = 0;
   logic [7:0] abits = 8'h00;
   int         cyc = 0;
   int         rises = 0;
   int         hi_chg = 0;
   int         rel_viol = 0;
   int         last_rise = 0;
   int         per_min = 0;
   int         per_max = 0;
   logic [7:0] addr_wire = 8'h00;
   logic       mack_bit = 1'b0;

   initial begin
      logic prev_scl, prev_sda, cur_scl, cur_sda;
      prev_scl = 1'b1;
      prev_sda = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         cur_scl = scl_bus;
         cur_sda = sda;
         if (clr_seen != clr_seq) begin
            clr_seen  = clr_seq;
            rises     = 0;
            hi_chg    = 0;
            rel_viol  = 0;
            per_min   = 32'h7fff_ffff;
            per_max   = 0;
            addr_wire = 8'h00;
            mack_bit  = 1'b0;
         end
         if (cur_scl && prev_scl && (cur_sda !== prev_sda)) hi_chg++;
         if (cur_scl && !prev_scl) begin
            if (rises < 8) addr_wire = {addr_wire[6:0], cur_sda};
            if (rises >= 1 && rises < 18) begin
               if (cyc - last_rise < per_min) per_min = cyc - last_rise;
               if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            last_rise = cyc;
            rises++;
         end
         if (cur_scl && (mode == M_DATA || mode == M_MACK) && !tb_drv && (cur_sda !== ~sl_drv))
            rel_viol++;

         if (cur_scl && prev_scl && prev_sda && !cur_sda) begin
            mode = M_ADDR;
            acnt = 0;
            sl_drv = 1'b0;
         end else if (cur_scl && prev_scl && !prev_sda && cur_sda) begin
            mode = M_IDLE;
            sl_drv = 1'b0;
         end else if (cur_scl && !prev_scl) begin
            if (mode == M_ADDR) begin
               abits = {abits[6:0], cur_sda};
               acnt++;
            end else if (mode == M_MACK) begin
               mack_bit = cur_sda;
            end
         end else if (!cur_scl && prev_scl) begin
            case (mode)
               M_ADDR: if (acnt == 8) begin
                  if (abits == 8'hAF) begin
                     sl_drv = 1'b1;
                     mode = M_ACK;
                  end else begin
                     mode = M_IDLE;
                  end
               end
               M_ACK: begin
                  mode = M_DATA;
                  dcnt = 0;
                  sl_drv = ~sw[7];
               end
               M_DATA: begin
                  dcnt++;
                  if (dcnt == 8) begin
                     sl_drv = 1'b0;
                     mode = M_MACK;
                  end else begin
                     sl_drv = ~sw[7-dcnt];
                  end
               end
               M_MACK: mode = M_IDLE;
               default: ;
            endcase
         end
         prev_scl = cur_scl;
         prev_sda = cur_sda;
      end
   end

   // Called at the negedge of the accept cycle; returns cycles from the
   // accept cycle to the rsp_valid cycle, and how many of those cycles had
   // cmd_ready high or busy low.
   task automatic wait_rsp(input bit use_b, input int limit, input bit keep_valid,
                           output int lat, output int rdy_cnt, output int bsy_lo);
      logic rv;
      lat = 0;
      rdy_cnt = 0;
      bsy_lo = 0;
      rv = 1'b0;
      while (!rv && lat < limit) begin
         @(negedge clk);
         lat++;
         if (!keep_valid) begin
            ifa.cmd_valid = 1'b0;
            ifb.cmd_valid = 1'b0;
         end
         rv = use_b ? ifb.rsp_valid : ifa.rsp_valid;
         if (use_b ? ifb.cmd_ready : ifa.cmd_ready) rdy_cnt++;
         if (!(use_b ? ifb.busy : ifa.busy)) bsy_lo++;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, rdy, blo;
      rst_n = 1'b0;
      ifa.cmd_valid = 1'b0;
      ifa.cmd_addr  = 7'h00;
      ifb.cmd_valid = 1'b0;
      ifb.cmd_addr  = 7'h00;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_scl", scl_a, 1'b1);
      chk("rst_sda", sda, 1'b1);
      chk("rst_ready", ifa.cmd_ready, 1'b1);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_rsp_valid", ifa.rsp_valid, 1'b0);
      chk("rst_rsp_data", ifa.rsp_data, 8'h00);
      chk("rst_rsp_nack", ifa.rsp_nack, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: acknowledged read of 0xA5 from 0x57
      sw = 8'hA5;
      @(negedge clk);
      clr_seq++;
      ifa.cmd_addr  = 7'h57;
      ifa.cmd_valid = 1'b1;
      chk("t1_ready", ifa.cmd_ready, 1'b1);
      wait_rsp(1'b0, 700, 1'b0, lat, rdy, blo);
      chk("t1_latency", lat, 625);          // 78*8+1
      chk("t1_data", ifa.rsp_data, 8'hA5);
      chk("t1_nack", ifa.rsp_nack, 1'b0);
      chk("t1_ready_low", rdy, 0);
      chk("t1_busy_high", blo, 0);
      @(negedge clk);
      chk("t1_pulse_width", ifa.rsp_valid, 1'b0);
      chk("t1_held_data", ifa.rsp_data, 8'hA5);
      repeat (4) @(negedge clk);
      chk("t1_scl_rises", rises, 19);
      chk("t1_addr_wire", addr_wire, 8'hAF);
      chk("t1_sda_hi_changes", hi_chg, 2);
      chk("t1_master_nack", mack_bit, 1'b1);
      chk("t1_released", rel_viol, 0);
      chk("t1_period_min", per_min, 32);
      chk("t1_period_max", per_max, 32);

      // 2: address NACK
      @(negedge clk);
      clr_seq++;
      ifa.cmd_addr  = 7'h22;
      ifa.cmd_valid = 1'b1;
      wait_rsp(1'b0, 400, 1'b0, lat, rdy, blo);
      chk("t2_latency", lat, 337);          // 42*8+1
      chk("t2_nack", ifa.rsp_nack, 1'b1);
      chk("t2_data", ifa.rsp_data, 8'h00);
      repeat (4) @(negedge clk);
      chk("t2_scl_rises", rises, 10);
      chk("t2_stop_seen", hi_chg, 2);
      chk("t2_bus_idle", sda, 1'b1);

      // 3: back-to-back with cmd_valid held
      sw = 8'h00;
      @(negedge clk);
      clr_seq++;
      ifa.cmd_addr  = 7'h57;
      ifa.cmd_valid = 1'b1;
      wait_rsp(1'b0, 700, 1'b1, lat, rdy, blo);
      chk("t3a_latency", lat, 625);
      chk("t3a_data", ifa.rsp_data, 8'h00);
      chk("t3a_nack", ifa.rsp_nack, 1'b0);
      chk("t3a_ready_low", rdy, 0);
      sw = 8'hFF;
      clr_seq++;
      @(negedge clk);
      chk("t3_reaccept_ready", ifa.cmd_ready, 1'b1);
      chk("t3_pulse_gone", ifa.rsp_valid, 1'b0);
      wait_rsp(1'b0, 700, 1'b0, lat, rdy, blo);
      chk("t3b_latency", lat, 625);
      chk("t3b_data", ifa.rsp_data, 8'hFF);
      chk("t3b_ready_low", rdy, 0);
      repeat (4) @(negedge clk);
      chk("t3b_released", rel_viol, 0);

      // 4: reset during READ slot 3, then recover
      sw = 8'hFF;
      @(negedge clk);
      clr_seq++;
      ifa.cmd_addr  = 7'h57;
      ifa.cmd_valid = 1'b1;
      @(negedge clk);
      ifa.cmd_valid = 1'b0;
      repeat (409) @(negedge clk);          // quarter 51: READ slot 3, Q1
      chk("t4_busy_before", ifa.busy, 1'b1);
      chk("t4_scl_before", scl_a, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_scl", scl_a, 1'b1);
      chk("t4_rst_sda", sda, 1'b1);
      chk("t4_rst_busy", ifa.busy, 1'b0);
      chk("t4_rst_ready", ifa.cmd_ready, 1'b1);
      chk("t4_rst_rsp_valid", ifa.rsp_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      tb_drv = 1'b1;
      repeat (4) @(posedge clk);
      tb_drv = 1'b0;
      repeat (4) @(posedge clk);
      sw = 8'h3C;
      @(negedge clk);
      clr_seq++;
      ifa.cmd_addr  = 7'h57;
      ifa.cmd_valid = 1'b1;
      wait_rsp(1'b0, 700, 1'b0, lat, rdy, blo);
      chk("t4_latency", lat, 625);
      chk("t4_data", ifa.rsp_data, 8'h3C);
      chk("t4_nack", ifa.rsp_nack, 1'b0);

      // 5: CLK_DIV=250 timing
      sw = 8'h5A;
      repeat (4) @(negedge clk);
      clr_seq++;
      ifb.cmd_addr  = 7'h57;
      ifb.cmd_valid = 1'b1;
      chk("t5_ready", ifb.cmd_ready, 1'b1);
      wait_rsp(1'b1, 19600, 1'b0, lat, rdy, blo);
      chk("t5_latency", lat, 19501);        // 78*250+1
      chk("t5_data", ifb.rsp_data, 8'h5A);
      chk("t5_nack", ifb.rsp_nack, 1'b0);
      repeat (4) @(negedge clk);
      chk("t5_period_min", per_min, 1000);
      chk("t5_period_max", per_max, 1000);
      chk("t5_scl_rises", rises, 19);
      chk("t5_sda_hi_changes", hi_chg, 2);
      chk("t5_released", rel_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
